// File: rtl/fifo_drain_decipher.sv
// fifo_drain_decipher: drains a read queue one word at a time, XORs each word with a session key (FIFO_DRAIN_DECIPHER_EN) and hands it downstream
module fifo_drain_decipher #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Cen,
  input  logic             Start,
  input  logic [WIDTH-1:0] Cipher_key,
  input  logic             QUEUE_Empty,
  input  logic             QUEUE_Last,
  input  logic [WIDTH-1:0] QUEUE_Data_Out,
  output logic             QUEUE_Cen,
  output logic             QUEUE_Read_Write,
  output logic [WIDTH-1:0] Plain_out,
  output logic             Plain_valid,
  input  logic             Plain_ready,
  output logic [5:0]       Word_count,
  output logic             Busy,
  output logic             Done
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, FIN} state_t;
  localparam logic [5:0] MAX = 6'(DEPTH);
  state_t           state;
  logic [WIDTH-1:0] key, key_in;
  logic             last;
  logic             fin_next;
`ifdef FIFO_DRAIN_DECIPHER_EN
  assign key_in = Cipher_key;
`else
  logic unused_key;
  assign unused_key = ^Cipher_key;
  assign key_in = '0;
`endif
  assign QUEUE_Read_Write = 1'b0;
  assign QUEUE_Cen = Cen && state == READ && !QUEUE_Empty && Word_count < MAX;
  assign fin_next = last || Word_count + 6'd1 == MAX;
  // session sequencer: one word in flight, everything frozen while Cen is low
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      key         <= '0;
      last        <= 1'b0;
      Plain_out   <= '0;
      Plain_valid <= 1'b0;
      Word_count  <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else if (Cen) begin
      case (state)
        IDLE: if (Start) begin
          key        <= key_in;
          Word_count <= '0;
          Busy       <= 1'b1;
          state      <= READ;
        end
        READ: begin
          last  <= QUEUE_Last;
          Done  <= !QUEUE_Cen;
          state <= QUEUE_Cen ? WAIT : FIN;
        end
        WAIT: begin
          Plain_out   <= QUEUE_Data_Out ^ key;
          Plain_valid <= 1'b1;
          state       <= OUT;
        end
        OUT: if (Plain_ready) begin
          Plain_valid <= 1'b0;
          Word_count  <= Word_count + 6'(Word_count != MAX);
          Done        <= fin_next;
          state       <= fin_next ? FIN : READ;
        end
        FIN: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_drain_decipher.sv
// tb_fifo_drain_decipher: randomized sessions against a queue-based reference model
module tb_fifo_drain_decipher;
  localparam int DEPTH = 48;
`ifdef FIFO_DRAIN_DECIPHER_EN
  localparam logic [31:0] LIT0 = 32'hE0045382;
`else
  localparam logic [31:0] LIT0 = 32'h12345678;
`endif
  logic clk = 0, reset = 1, Cen = 1, Start = 0, Plain_ready = 0;
  logic [31:0] Cipher_key = 0;
  logic QUEUE_Empty, QUEUE_Last, QUEUE_Cen, QUEUE_Read_Write, Plain_valid, Busy, Done;
  logic [31:0] QUEUE_Data_Out, Plain_out;
  logic [5:0] Word_count;
  logic [31:0] mem [64];
  logic [31:0] q_data = 0;
  int q_rd = 0, q_cnt = 0, q_ld_n = 0, ld_n = 0;
  logic q_load = 0;
  logic [31:0] exp_q [$];
  int checks = 0, errors = 0, strobes = 0, n_exp = 0, done_cnt = 0;
  int rdy_pct = 100, cen_pct = 100;
  logic auto = 0;

  fifo_drain_decipher #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Cen(Cen), .Start(Start), .Cipher_key(Cipher_key),
    .QUEUE_Empty(QUEUE_Empty), .QUEUE_Last(QUEUE_Last), .QUEUE_Data_Out(QUEUE_Data_Out),
    .QUEUE_Cen(QUEUE_Cen), .QUEUE_Read_Write(QUEUE_Read_Write), .Plain_out(Plain_out),
    .Plain_valid(Plain_valid), .Plain_ready(Plain_ready), .Word_count(Word_count),
    .Busy(Busy), .Done(Done));

  always #5 clk = ~clk;

  assign QUEUE_Empty = q_cnt == 0;
  assign QUEUE_Last = q_cnt == 1;
  assign QUEUE_Data_Out = q_data;

  // queue: read data appears the cycle after a strobe
  always @(posedge clk)
    if (q_load) begin
      q_rd <= 0;
      q_cnt <= q_ld_n;
    end else if (QUEUE_Cen) begin
      q_data <= mem[q_rd];
      q_rd <= q_rd + 1;
      q_cnt <= q_cnt - 1;
    end

  function automatic logic [31:0] model(input logic [31:0] w, input logic [31:0] k);
`ifdef FIFO_DRAIN_DECIPHER_EN
    return w ^ k;
`else
    return w;
`endif
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic driver();
    forever begin
      @(posedge clk);
      #1;
      if (auto) begin
        Cen = $urandom_range(99) < cen_pct;
        Plain_ready = $urandom_range(99) < rdy_pct;
      end
    end
  endtask

  task automatic monitor();
    logic hv, dp;
    logic [31:0] hd, e;
    hv = 0; dp = 0; hd = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hv = 0;
        dp = 0;
      end else begin
        if (QUEUE_Cen) begin
          strobes++;
          chk(Cen && !Plain_valid && !QUEUE_Read_Write && q_cnt > 0 && strobes <= n_exp, "strobe", strobes, n_exp);
        end
        if (hv) chk(Plain_valid && Plain_out == hd, "stable", Plain_out, hd);
        if (Plain_valid && Plain_ready && Cen) begin
          e = exp_q.size() > 0 ? exp_q.pop_front() : ~Plain_out;
          chk(Plain_out == e, "data", Plain_out, e);
          hv = 0;
        end else begin
          hv = Plain_valid;
          hd = Plain_out;
        end
        if (Done && !dp) begin
          chk(32'(Word_count) == n_exp && exp_q.size() == 0 && strobes == n_exp, "done_count", 32'(Word_count), n_exp);
          done_cnt++;
        end
        dp = Done;
      end
    end
  endtask

  task automatic load(input int n, input bit fixed);
    for (int i = 0; i < n; i++) mem[i] = fixed ? 32'h12345678 + 32'h11111111 * i : $urandom;
    ld_n = n;
    q_ld_n = n;
    q_load = 1;
    @(posedge clk);
    #1;
    q_load = 0;
  endtask

  task automatic hold(input bit stall);
    logic [31:0] po;
    logic pv, b, d;
    logic [5:0] wc;
    auto = 0;
    if (stall) begin
      Cen = 1;
      Plain_ready = 0;
      for (int c = 0; c < 10 && !Plain_valid; c++) begin
        @(posedge clk);
        #1;
      end
      chk(Plain_valid, "stall_valid", 32'(Plain_valid), 1);
    end else Cen = 0;
    po = Plain_out; pv = Plain_valid; wc = Word_count; b = Busy; d = Done;
    repeat (stall ? 5 : 4) begin
      @(negedge clk);
      chk(!QUEUE_Cen && Plain_out == po && Plain_valid == pv && Word_count == wc && Busy == b && Done == d,
          stall ? "stall" : "freeze", Plain_out, po);
    end
    auto = 1;
  endtask

  task automatic run(input logic [31:0] k, input int rp, input int cp, input int hold_at, input bit stall, input bit lat);
    int d0;
    n_exp = ld_n < DEPTH ? ld_n : DEPTH;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(model(mem[i], k));
    strobes = 0;
    d0 = done_cnt;
    auto = 0; Cen = 1; Start = 1; Cipher_key = k;
    @(posedge clk);
    #1;
    Start = 0; Cipher_key = $urandom; rdy_pct = rp; cen_pct = cp; auto = 1;
    @(negedge clk);
    chk(Word_count == 0 && Busy, "start", 32'(Word_count), 0);
    if (lat) begin
      @(negedge clk);
      if (ld_n == 0) chk(Done && Word_count == 0, "empty_done", 32'(Done), 1);
      else chk(!Plain_valid, "lat_early", 32'(Plain_valid), 0);
      if (ld_n > 0) begin
        @(negedge clk);
        chk(Plain_valid && Plain_out == LIT0, "lat_first", Plain_out, LIT0);
      end
    end
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      @(posedge clk);
      #1;
      if (c == hold_at) hold(stall);
    end
    if (done_cnt == d0) chk(0, "timeout", 0, 1);
    auto = 0; Cen = 1;
    @(posedge clk);
    #1;
    chk(!Busy && !Done, "idle", {Busy, Done}, 0);
  endtask

  initial begin
    int s, c;
    fork
      driver();
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk(Plain_out == 0 && !Plain_valid, "rst_plain", Plain_out, 0);
    chk(Word_count == 0, "rst_count", 32'(Word_count), 0);
    chk(!Busy && !Done, "rst_busy_done", {Busy, Done}, 0);
    chk(!QUEUE_Cen && !QUEUE_Read_Write, "rst_queue", {QUEUE_Cen, QUEUE_Read_Write}, 0);
    load(3, 1);
    reset = 0;
    run(32'hF23005FA, 100, 100, -1, 0, 1);
    load(0, 0);
    run($urandom, 100, 100, -1, 0, 1);
    load(50, 0);
    run($urandom, 100, 100, -1, 0, 0);
    load(3, 0);
    run($urandom, 100, 100, 0, 1, 0);
    load(4, 0);
    run($urandom, 100, 100, 3, 0, 0);
    for (int i = 0; i < 10; i++) begin
      load($urandom_range(12), 0);
      run($urandom, $urandom_range(30, 100), $urandom_range(60, 100), $urandom_range(0, 12) - 2, 0, 0);
    end
    load(5, 0);
    n_exp = 5;
    for (int i = 0; i < 5; i++) exp_q.push_back(model(mem[i], 32'h0BADF00D));
    strobes = 0;
    auto = 0; Cen = 1; Plain_ready = 1; Start = 1; Cipher_key = 32'h0BADF00D;
    @(posedge clk);
    #1;
    Start = 0;
    s = 0; c = 0;
    while (s < 2 && c < 40) begin
      @(negedge clk);
      c++;
      if (QUEUE_Cen) s++;
    end
    chk(s == 2, "second_strobe", s, 2);
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    chk(!Plain_valid && Plain_out == 0 && Word_count == 0, "areset_data", Plain_out, 0);
    chk(!Busy && !Done && !QUEUE_Cen, "areset_ctrl", {Busy, Done, QUEUE_Cen}, 0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    load(4, 0);
    run($urandom, 70, 90, -1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_drain_decipher.md
FIFO_DRAIN_DECIPHER -- requirements
Module: fifo_drain_decipher

Interface
REQ-001 Parameter WIDTH, default 32, data and key width in bits.
REQ-002 Parameter DEPTH, default 48, maximum words drained per session.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port Cen  input  1  block enable; low freezes all state and outputs.
REQ-006 Port Start  input  1  one-cycle pulse that begins a drain session.
REQ-007 Port Cipher_key  input  WIDTH  key, sampled on accepted Start.
REQ-008 Port QUEUE_Empty  input  1  queue holds no words.
REQ-009 Port QUEUE_Last  input  1  queue holds exactly one word.
REQ-010 Port QUEUE_Data_Out  input  WIDTH  queue read data, valid one cycle after a read strobe.
REQ-011 Port QUEUE_Cen  output  1  queue access strobe, one cycle per word.
REQ-012 Port QUEUE_Read_Write  output  1  queue direction; held 0 (read) at all times.
REQ-013 Port Plain_out  output  WIDTH  deciphered word.
REQ-014 Port Plain_valid  output  1  Plain_out holds a word.
REQ-015 Port Plain_ready  input  1  downstream accepts Plain_out this cycle.
REQ-016 Port Word_count  output  6  words delivered in the current session.
REQ-017 Port Busy  output  1  session in progress.
REQ-018 Port Done  output  1  one-cycle pulse at session end.

Function
REQ-019 FSM states: IDLE, READ, WAIT, OUT, FIN.
REQ-020 IDLE: Start=1 latches Cipher_key, clears Word_count, sets Busy, goes to READ; Start is ignored in all other states.
REQ-021 READ: with QUEUE_Empty=0 and Word_count<DEPTH, assert QUEUE_Cen for exactly one cycle and go to WAIT; otherwise go to FIN with no strobe.
REQ-022 WAIT: capture QUEUE_Data_Out XOR latched key into Plain_out, record the QUEUE_Last value sampled in READ, and go to OUT.
REQ-023 OUT: Plain_valid=1 and Plain_out stable until Plain_valid and Plain_ready are both 1 on a clock edge; on that edge increment Word_count, then go to FIN if the recorded last flag was 1 or Word_count reaches DEPTH, else go to READ.
REQ-024 FIN: assert Done for one cycle, clear Busy, return to IDLE; Word_count holds until the next Start.
REQ-025 Latency: Start to first Plain_valid equals 3 cycles with a non-empty queue; there is at most one word in flight.
REQ-026 Plain_ready arriving before Plain_valid has no effect; Plain_valid never drops without a transfer.
REQ-027 Cen=0 in any state: no transitions, QUEUE_Cen=0, other outputs hold; resume exactly where frozen.
REQ-028 Empty queue at Start: READ goes straight to FIN; Done pulses with Word_count=0.
REQ-029 Word_count saturates at DEPTH and never wraps.

Reset
REQ-030 reset=1 forces IDLE asynchronously, mid-session included: QUEUE_Cen=0, QUEUE_Read_Write=0, Plain_out=0, Plain_valid=0, Word_count=0, Busy=0, Done=0, latched key=0.
REQ-031 First Start is honoured on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro FIFO_DRAIN_DECIPHER_EN defined: Plain_out = QUEUE_Data_Out XOR latched key.
REQ-033 Macro undefined: Plain_out = QUEUE_Data_Out unchanged; key port ignored, all timing identical.

Verification
REQ-034 Queue preloaded with 3 words, key 32'hF23005FA, Plain_ready=1 -> 3 words out each equal to stored XOR key, Done pulse, Word_count=3.
REQ-035 Queue preloaded with 48 words -> 48 transfers, no QUEUE_Cen after word 48, Done, Word_count=48.
REQ-036 Empty queue, Start -> zero QUEUE_Cen strobes, Done 2 cycles after Start, Word_count=0.
REQ-037 Plain_ready held 0 for 5 cycles during OUT -> Plain_valid and Plain_out stable, no QUEUE_Cen until transfer.
REQ-038 reset pulsed during WAIT of word 2 -> all outputs at reset values immediately; next Start restarts with Word_count=0.
REQ-039 Cen low for 4 cycles mid-session -> no strobes or state change; output word sequence identical to uninterrupted run.
